// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB-lite slave-side bus between three masters.
// Round-robin arbitration with a registered one-hot grant, HLOCK and
// fixed-length burst protection, and a data-phase-delayed HWDATA owner.
// Optional build macro: ARB_FIXED_PRIORITY_EN (master 1 > master 2 > master 3).
module ahb_master_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HBUSREQ_1,
  input  logic              HBUSREQ_2,
  input  logic              HBUSREQ_3,
  input  logic              HLOCK_1,
  input  logic              HLOCK_2,
  input  logic              HLOCK_3,
  input  logic [ADDR_W-1:0] HADDR_1,
  input  logic [ADDR_W-1:0] HADDR_2,
  input  logic [ADDR_W-1:0] HADDR_3,
  input  logic [1:0]        HTRANS_1,
  input  logic [1:0]        HTRANS_2,
  input  logic [1:0]        HTRANS_3,
  input  logic              HWRITE_1,
  input  logic              HWRITE_2,
  input  logic              HWRITE_3,
  input  logic [2:0]        HSIZE_1,
  input  logic [2:0]        HSIZE_2,
  input  logic [2:0]        HSIZE_3,
  input  logic [2:0]        HBURST_1,
  input  logic [2:0]        HBURST_2,
  input  logic [2:0]        HBURST_3,
  input  logic [DATA_W-1:0] HWDATA_1,
  input  logic [DATA_W-1:0] HWDATA_2,
  input  logic [DATA_W-1:0] HWDATA_3,
  input  logic              HREADY,
  output logic [2:0]        HGRANT,
  output logic [1:0]        HMASTER,
  output logic              HMASTLOCK,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [2:0] req;
  logic [2:0] lck;
  logic [1:0] hmaster_d;    // data-phase owner, selects HWDATA
  logic [3:0] cnt;          // remaining beats of the current fixed-length burst
  logic [3:0] next_cnt;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic       any_req;
  logic       win_lock;
  logic       owner_lock;
  logic       owner_req;
  logic       arb_point;

  assign req = {HBUSREQ_3, HBUSREQ_2, HBUSREQ_1};
  assign lck = {HLOCK_3, HLOCK_2, HLOCK_1};

  // Address/control mux by address-phase owner, write data mux by data-phase owner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    HADDR      = HADDR_1;
    HTRANS     = HTRANS_1;
    HWRITE     = HWRITE_1;
    HSIZE      = HSIZE_1;
    HBURST     = HBURST_1;
    owner_lock = HLOCK_1;
    owner_req  = HBUSREQ_1;
    HWDATA     = HWDATA_1;
    case (HMASTER)
      2'd1: begin
        HADDR = HADDR_2; HTRANS = HTRANS_2; HWRITE = HWRITE_2;
        HSIZE = HSIZE_2; HBURST = HBURST_2;
        owner_lock = HLOCK_2; owner_req = HBUSREQ_2;
      end
      2'd2: begin
        HADDR = HADDR_3; HTRANS = HTRANS_3; HWRITE = HWRITE_3;
        HSIZE = HSIZE_3; HBURST = HBURST_3;
        owner_lock = HLOCK_3; owner_req = HBUSREQ_3;
      end
      default: ;
    endcase
    case (hmaster_d)
      2'd1:    HWDATA = HWDATA_2;
      2'd2:    HWDATA = HWDATA_3;
      default: ;
    endcase
  end

  // Beat counter update for the transfer accepted on this edge.
  always_comb begin
    next_cnt = cnt;
    if (HREADY) begin
      case (HTRANS)
        TR_NONSEQ: begin
          case (HBURST)
            3'b010, 3'b011: next_cnt = 4'd3;
            3'b100, 3'b101: next_cnt = 4'd7;
            3'b110, 3'b111: next_cnt = 4'd15;
            default:        next_cnt = 4'd0;
          endcase
        end
        TR_SEQ:  next_cnt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        TR_BUSY: next_cnt = cnt;
        TR_IDLE: next_cnt = 4'd0;
        default: next_cnt = cnt;
      endcase
    end
  end

  assign arb_point = HREADY && (next_cnt == 4'd0) && !(owner_lock && owner_req);
  assign any_req   = |req;

  // Winner selection among current requesters.
  always_comb begin
    winner   = 2'd0;
    win_lock = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    if (req[0])      winner = 2'd0;
    else if (req[1]) winner = 2'd1;
    else if (req[2]) winner = 2'd2;
`else
    for (int k = 3; k >= 1; k--) begin
      // Walk from farthest to nearest so the nearest requester after rr_ptr wins.
      int idx;
      idx = (int'(rr_ptr) + k) % 3;
      if (req[idx]) winner = 2'(idx);
    end
`endif
    case (winner)
      2'd1:    win_lock = lck[1];
      2'd2:    win_lock = lck[2];
      default: win_lock = lck[0];
    endcase
  end

  // Grant, owner, lock, data-phase owner, beat count and round-robin state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      HGRANT    <= 3'b001;
      HMASTER   <= 2'd0;
      HMASTLOCK <= 1'b0;
      hmaster_d <= 2'd0;
      cnt       <= 4'd0;
      rr_ptr    <= 2'd0;
    end else if (HREADY) begin
      cnt       <= next_cnt;
      hmaster_d <= HMASTER;
      if (arb_point) begin
        if (any_req) begin
          HGRANT    <= 3'b001 << winner;
          HMASTER   <= winner;
          HMASTLOCK <= win_lock;
`ifdef ARB_FIXED_PRIORITY_EN
          rr_ptr    <= 2'd0;
`else
          rr_ptr    <= winner;
`endif
        end else begin
          HGRANT    <= 3'b001;
          HMASTER   <= 2'd0;
          HMASTLOCK <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed table-driven bench for ahb_master_arbiter, plus hand-written
// sequences for reset behaviour and reset in the middle of a locked burst.
module tb_ahb_master_arbiter;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] BUSY  = 2'b01;
  localparam logic [1:0] NSEQ  = 2'b10;
  localparam logic [1:0] SEQ   = 2'b11;
  localparam logic [2:0] SINGL = 3'b000;
  localparam logic [2:0] INCR4 = 3'b011;
  localparam logic [2:0] INCR8 = 3'b101;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [2:0] grant;
    logic [1:0] master;
    logic       mlock;
    logic [1:0] downer;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] lock = '0;
  logic [1:0] trans = IDLE;
  logic [2:0] burst = SINGL;
  logic hready = 1'b1;
  logic [31:0] addr_v [3];
  logic [31:0] wd_v [3];

  logic [2:0]  HGRANT;
  logic [1:0]  HMASTER;
  logic        HMASTLOCK;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;

  int n_tests = 0;
  int n_fail = 0;
  vec_t vt[$];

  always #5 clk = ~clk;

  ahb_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .HBUSREQ_1(req[0]), .HBUSREQ_2(req[1]), .HBUSREQ_3(req[2]),
    .HLOCK_1(lock[0]), .HLOCK_2(lock[1]), .HLOCK_3(lock[2]),
    .HADDR_1(addr_v[0]), .HADDR_2(addr_v[1]), .HADDR_3(addr_v[2]),
    .HTRANS_1(trans), .HTRANS_2(trans), .HTRANS_3(trans),
    .HWRITE_1(1'b0), .HWRITE_2(1'b1), .HWRITE_3(1'b0),
    .HSIZE_1(3'd2), .HSIZE_2(3'd1), .HSIZE_3(3'd0),
    .HBURST_1(burst), .HBURST_2(burst), .HBURST_3(burst),
    .HWDATA_1(wd_v[0]), .HWDATA_2(wd_v[1]), .HWDATA_3(wd_v[2]),
    .HREADY(hready),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] l, input logic [1:0] t,
                     input logic [2:0] b, input logic rdy, input logic [2:0] g,
                     input logic [1:0] m, input logic ml, input logic [1:0] d);
    vec_t v;
    v.req = r; v.lock = l; v.trans = t; v.burst = b; v.ready = rdy;
    v.grant = g; v.master = m; v.mlock = ml; v.downer = d;
    vt.push_back(v);
  endtask

  // Apply inputs, take one edge, then compare post-edge state away from the edge.
  task automatic step(input string tag, input logic [2:0] r, input logic [2:0] l,
                      input logic [1:0] t, input logic [2:0] b, input logic rdy,
                      input logic [2:0] g, input logic [1:0] m, input logic ml,
                      input logic [1:0] d);
    req = r; lock = l; trans = t; burst = b; hready = rdy;
    @(posedge clk);
    #1;
    check({tag, " grant"},  64'(HGRANT),    64'(g));
    check({tag, " master"}, 64'(HMASTER),   64'(m));
    check({tag, " mlock"},  64'(HMASTLOCK), 64'(ml));
    check({tag, " hwdata"}, 64'(HWDATA),    64'(wd_v[d]));
    check({tag, " haddr"},  64'(HADDR),     64'(addr_v[m]));
  endtask

  initial begin
    addr_v[0] = 32'h1000_0010; addr_v[1] = 32'h2000_0020; addr_v[2] = 32'h3000_0030;
    wd_v[0]   = 32'hD000_0001; wd_v[1]   = 32'hD000_0002; wd_v[2]   = 32'hD000_0003;

    // Reset for two cycles, release with no requests: parked on master 1.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst grant",  64'(HGRANT), 64'(3'b001));
    check("rst master", 64'(HMASTER), 64'd0);
    check("rst mlock",  64'(HMASTLOCK), 64'd0);
    check("rst hwdata", 64'(HWDATA), 64'(wd_v[0]));
    check("rst hwrite", 64'(HWRITE), 64'd0);
    check("rst hsize",  64'(HSIZE), 64'd2);
    step("idle", 3'b000, 3'b000, IDLE, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);

`ifndef ARB_FIXED_PRIORITY_EN
    // Round-robin with everyone requesting SINGLE transfers.
    add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b100, 2'd2, 1'b0, 2'd1);
    add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd2);
    add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b100, 2'd2, 1'b0, 2'd1);
    add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd2);
    // Master 2 takes the bus, runs INCR4 while master 3 waits.
    add(3'b010, 3'b000, IDLE, SINGL, 1'b1, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b110, 3'b000, NSEQ, INCR4, 1'b1, 3'b010, 2'd1, 1'b0, 2'd1);
    add(3'b110, 3'b000, SEQ,  INCR4, 1'b1, 3'b010, 2'd1, 1'b0, 2'd1);
    add(3'b110, 3'b000, SEQ,  INCR4, 1'b1, 3'b010, 2'd1, 1'b0, 2'd1);
    add(3'b110, 3'b000, SEQ,  INCR4, 1'b1, 3'b100, 2'd2, 1'b0, 2'd1);
    // Master 1 locked for three transfers while master 2 requests.
    add(3'b001, 3'b001, IDLE, SINGL, 1'b1, 3'b001, 2'd0, 1'b1, 2'd2);
    add(3'b011, 3'b001, NSEQ, SINGL, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0);
    add(3'b011, 3'b001, NSEQ, SINGL, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0);
    add(3'b011, 3'b001, NSEQ, SINGL, 1'b1, 3'b001, 2'd0, 1'b1, 2'd0);
    add(3'b011, 3'b000, NSEQ, SINGL, 1'b1, 3'b010, 2'd1, 1'b0, 2'd0);
    // HREADY low for three cycles with master 3 requesting: everything frozen.
    add(3'b100, 3'b000, NSEQ, SINGL, 1'b0, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b100, 3'b000, NSEQ, SINGL, 1'b0, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b100, 3'b000, NSEQ, SINGL, 1'b0, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b100, 3'b000, NSEQ, SINGL, 1'b1, 3'b100, 2'd2, 1'b0, 2'd1);
    // Park with no requests; the pointer must not move while parked.
    add(3'b000, 3'b000, IDLE, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd2);
    add(3'b011, 3'b000, IDLE, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);
    add(3'b001, 3'b000, IDLE, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);
`else
    // Fixed priority: master 1 wins every arbitration point.
    for (int i = 0; i < 6; i++)
      add(3'b111, 3'b000, NSEQ, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);
    add(3'b110, 3'b000, IDLE, SINGL, 1'b1, 3'b010, 2'd1, 1'b0, 2'd0);
    add(3'b011, 3'b000, IDLE, SINGL, 1'b1, 3'b001, 2'd0, 1'b0, 2'd1);
`endif

    foreach (vt[i])
      step($sformatf("v%0d", i), vt[i].req, vt[i].lock, vt[i].trans, vt[i].burst,
           vt[i].ready, vt[i].grant, vt[i].master, vt[i].mlock, vt[i].downer);

    // Master 3 gets a locked INCR8, reset hits with 5 beats remaining.
    step("lk3",  3'b100, 3'b100, IDLE,  SINGL, 1'b1, 3'b100, 2'd2, 1'b1, 2'd0);
    step("b8ns", 3'b101, 3'b100, NSEQ,  INCR8, 1'b1, 3'b100, 2'd2, 1'b1, 2'd2);
    step("b8s1", 3'b101, 3'b100, SEQ,   INCR8, 1'b1, 3'b100, 2'd2, 1'b1, 2'd2);
    step("b8s2", 3'b101, 3'b100, SEQ,   INCR8, 1'b1, 3'b100, 2'd2, 1'b1, 2'd2);
    reset = 1'b1;
    step("mrst", 3'b101, 3'b100, SEQ,   INCR8, 1'b1, 3'b001, 2'd0, 1'b0, 2'd0);
    reset = 1'b0;
    // BUSY holds the count; a cleared counter lets master 3 win right away.
    step("post", 3'b100, 3'b000, BUSY,  INCR8, 1'b1, 3'b100, 2'd2, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares one AHB-lite slave-side bus (decoder plus response multiplexer) between three bus masters.
- Arbitrates HBUSREQ requests round-robin and registers a one-hot grant.
- Muxes the granted master's address/control onto the shared bus, and muxes HWDATA using a data-phase-delayed owner.
- Honours HLOCK and fixed-length bursts; all grant changes occur only on HREADY=1 edges.

Parameters:
ADDR_W, 32, width of HADDR
DATA_W, 32, width of HWDATA

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
HBUSREQ_1, HBUSREQ_2, HBUSREQ_3  input  1 each  master bus requests
HLOCK_1, HLOCK_2, HLOCK_3  input  1 each  master lock requests
HADDR_1..3  input  ADDR_W each  master addresses
HTRANS_1..3  input  2 each  master transfer types
HWRITE_1..3  input  1 each  master write flags
HSIZE_1..3  input  3 each  master sizes
HBURST_1..3  input  3 each  master burst types
HWDATA_1..3  input  DATA_W each  master write data
HREADY  input  1  shared-bus ready, from the response multiplexer
HGRANT  output  3  one-hot grant, bit0 = master 1
HMASTER  output  2  address-phase owner: 0, 1 or 2
HMASTLOCK  output  1  locked-sequence indication
HADDR, HTRANS, HWRITE, HSIZE, HBURST  output  as inputs  muxed address/control
HWDATA  output  DATA_W  muxed write data

Behaviour:
Interface:
- One clock (clk); reset is synchronous and active-high (reset).

Reset (sampled on the clk edge):
- HGRANT=3'b001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0.
- Beat counter=0, round-robin pointer=0.
- Reset mid-burst or mid-lock aborts immediately; no state survives.

Address/data muxing:
- Address/control outputs are combinational muxes selected by HMASTER.
- HWDATA is selected by HMASTER_D (internal), which loads HMASTER on every edge with HREADY=1.
- HMASTER_D holds while HREADY=0.

Beat counter (updates only when HREADY=1):
- HTRANS=NONSEQ with HBURST WRAP4/INCR4 loads 3; WRAP8/INCR8 loads 7; WRAP16/INCR16 loads 15; SINGLE/INCR loads 0.
- SEQ decrements, saturating at 0.
- BUSY holds the count.
- IDLE clears the count (early termination).
- next_cnt denotes the post-update value.

Arbitration point:
- Edge where HREADY=1 AND next_cnt==0 AND NOT (HLOCK of current owner AND HBUSREQ of current owner).
- Outside an arbitration point, HGRANT, HMASTER and HMASTLOCK hold.

Grant selection at an arbitration point:
- Round-robin: search requesters starting at (rr_ptr+1) mod 3; first asserted HBUSREQ wins.
- If the current owner is the only requester, it keeps the grant.
- No requests: park on master 0.
- rr_ptr <= winner index; rr_ptr is unchanged when parking.
- Latency: request to HGRANT = 1 cycle minimum. HMASTER updates on the same edge as HGRANT, so the new owner drives address on the next cycle.

HMASTLOCK:
- Loads the winner's HLOCK at each arbitration point.
- Cleared when the locked owner drops HLOCK at an arbitration point.

Simultaneous events:
- A request arriving on the same edge that the owner deasserts is considered at that edge.
- HREADY=0 freezes everything except the combinational muxes.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: selection uses fixed priority, master 1 > master 2 > master 3; rr_ptr is unused (tie to 0). Lock and burst protection are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset held for 2 cycles, then released with no requests -> HGRANT=001, HMASTER=0, HTRANS = HTRANS_1, HWDATA = HWDATA_1.
2. HBUSREQ_1=HBUSREQ_2=HBUSREQ_3=1 constantly, SINGLE NONSEQ transfers, HREADY=1 -> HMASTER sequence 1,2,0,1,2,0 (rr from reset ptr 0); HWDATA owner lags HMASTER by exactly 1 cycle.
3. Master 2 issues INCR4 (NONSEQ+3 SEQ) while master 3 requests -> grant stays 010 for all 4 address beats; switches to 100 on the edge accepting the 4th beat.
4. Master 1 locked (HLOCK_1=1), 3 transfers, with master 2 requesting -> HMASTLOCK=1, grant held at 001 until HLOCK_1 drops, then 010 on the next HREADY=1 edge.
5. HREADY=0 for 3 cycles during the data phase while master 3 requests -> HGRANT, HMASTER and HMASTER_D unchanged until HREADY returns to 1.
6. Reset asserted mid-INCR8 (counter=5) -> next edge: HGRANT=001, counter 0, HMASTLOCK=0; with ARB_FIXED_PRIORITY_EN defined and all requesting -> master 1 is granted every arbitration point.
